// File: rtl/clk_div_by_5.sv
// clk_div_by_5: divides clk by DIV with a 50% duty cycle on clk_out, odd DIV included.
// Optional feature macro CLKDIV_TICK_EN adds a one-clk-cycle tick at each clk_out rise.
`timescale 1ns/1ps
module clk_div_by_5 #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic rstn,
  output logic clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic tick
`endif
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  generate
    if (DIV < 2) begin : gen_bad_div
      $error("clk_div_by_5: DIV must be >= 2, got %0d", DIV);
    end
  endgenerate

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          q_p_reg;

  always_comb begin
    cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
  end

  // Resetting cnt to LAST makes the first count after release 0, so clk_out rises there.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_reg <= LAST;
      q_p_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      q_p_reg <= (cnt_next < HALF);
    end
  end

  generate
    if (DIV % 2 == 1) begin : gen_odd
      logic q_n_reg;

      // Half-period delayed copy stretches the high phase by half a clk cycle.
      always_ff @(negedge clk) begin
        if (!rstn) begin
          q_n_reg <= 1'b0;
        end else begin
          q_n_reg <= q_p_reg;
        end
      end

      assign clk_out = q_p_reg | q_n_reg;
    end else begin : gen_even
      assign clk_out = q_p_reg;
    end
  endgenerate

`ifdef CLKDIV_TICK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tick <= 1'b0;
    end else begin
      tick <= (cnt_next == '0);
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_by_5.sv
// tb_clk_div_by_5: checks DIV = 5, 4, 2, 7 instances against a half-cycle phase model
// plus hand-computed edge timings (rise/fall times, period, negedge alignment).
`timescale 1ns/1ps
module tb_clk_div_by_5;

  localparam int NI = 4;
  localparam int DIVS [NI] = '{5, 4, 2, 7};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NI-1:0] co;
`ifdef CLKDIV_TICK_EN
  logic [NI-1:0] tk;
`endif

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : gen_dut
      clk_div_by_5 #(.DIV(DIVS[gi])) u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .clk_out(co[gi])
`ifdef CLKDIV_TICK_EN
        ,
        .tick   (tk[gi])
`endif
      );
    end
  endgenerate

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: h counts half clk periods since the posedge that sampled rstn high.
  // clk_out is high for the first DIV half periods of every 2*DIV.
  typedef enum {S_UNK, S_PEND, S_RST, S_RUN} mstate_t;
  mstate_t ms = S_UNK;
  int h = 0;

  always @(clk) begin
    #1;
    if (clk) begin
      if (!rstn) ms = S_PEND;
      else if (ms == S_RUN) h++;
      else if (ms != S_UNK) begin
        ms = S_RUN;
        h = 0;
      end
    end else begin
      if (ms == S_PEND) ms = S_RST;
      else if (ms == S_RUN) h++;
    end
    for (int i = 0; i < NI; i++) begin
      if (ms == S_RST)
        chk_bit($sformatf("clk_out_reset_div%0d", DIVS[i]), co[i], 1'b0);
      else if (ms == S_RUN)
        chk_bit($sformatf("clk_out_div%0d_h%0d", DIVS[i], h), co[i],
                (h % (2 * DIVS[i])) < DIVS[i]);
`ifdef CLKDIV_TICK_EN
      if (ms != S_UNK)
        chk_bit($sformatf("tick_div%0d", DIVS[i]), tk[i],
                (ms == S_RUN) && ((h % (2 * DIVS[i])) < 2));
`endif
    end
  end

  longint rise [NI][$];
  longint fall [NI][$];

  generate
    for (gi = 0; gi < NI; gi++) begin : gen_mon
      always @(posedge co[gi]) rise[gi].push_back($time);
      always @(negedge co[gi]) fall[gi].push_back($time);
    end
  endgenerate

  task automatic clear_q();
    for (int i = 0; i < NI; i++) begin
      rise[i].delete();
      fall[i].delete();
    end
  endtask

  // Hand-computed edge timings for one instance over np periods, Tclk = 10 ns.
  task automatic chk_edges(input int idx, input int np, input longint t0,
                           input longint hi_ns, input longint per_ns);
    n_checks++;
    if (rise[idx].size() < np + 1 || fall[idx].size() < np) begin
      n_fail++;
      $display("FAIL edge_count_div%0d: got %0d rises %0d falls, expected >= %0d/%0d",
               DIVS[idx], rise[idx].size(), fall[idx].size(), np + 1, np);
      return;
    end
    chk($sformatf("first_rise_div%0d", DIVS[idx]), rise[idx][0], t0);
    for (int k = 0; k < np; k++) begin
      chk($sformatf("high_ns_div%0d_p%0d", DIVS[idx], k), fall[idx][k] - rise[idx][k], hi_ns);
      chk($sformatf("period_ns_div%0d_p%0d", DIVS[idx], k), rise[idx][k+1] - rise[idx][k], per_ns);
    end
  endtask

  longint t_p0;
  bit synced;

  initial begin
    // Phase 1: reset, release, run over 10 periods of each divisor.
    repeat (3) @(posedge clk);
    #2;
    clear_q();
    rstn = 1'b1;
    @(posedge clk);
    t_p0 = $time;
    repeat (150) @(posedge clk);
    #2;
    chk_edges(0, 10, t_p0, 25, 50);
    chk_edges(1, 10, t_p0, 20, 40);
    chk_edges(2, 10, t_p0, 10, 20);
    chk_edges(3, 10, t_p0, 35, 70);
    // DIV=7 falls sit on negedges (t multiple of 10), rises on posedges (t = 5 mod 10).
    if (fall[3].size() >= 3 && rise[3].size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("div7_fall_on_negedge_%0d", k), fall[3][k] % 10, 0);
        chk($sformatf("div7_rise_on_posedge_%0d", k), rise[3][k] % 10, 5);
      end
    end

    // Phase 2: rstn low at the 2nd posedge of a DIV=5 high phase.
    synced = 1'b0;
    for (int c = 0; c < 20 && !synced; c++) begin
      @(posedge clk);
      #2;
      if (ms == S_RUN && (h % 10) == 0) synced = 1'b1;
    end
    n_checks++;
    if (!synced) begin
      n_fail++;
      $display("FAIL sync_high_phase: got no DIV=5 rise within 20 cycles, expected one");
    end
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_bit("mid_reset_cleared_div5", co[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_bit("mid_reset_held_div5", co[0], 1'b0);
    #1;
    clear_q();
    rstn = 1'b1;
    @(posedge clk);
    t_p0 = $time;
    repeat (40) @(posedge clk);
    #2;
    chk_edges(0, 2, t_p0, 25, 50);
    chk_edges(3, 1, t_p0, 35, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
